// File: rtl/rob_pkg.sv
// Sizing, entry layout and tag/index helpers shared by the reorder buffer files.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package rob_pkg;

    localparam int ROBsize      = 32;                   // entries, power of two >= 2
    localparam int IDX_W        = $clog2(ROBsize);
    localparam int mapValueSize = $clog2(ROBsize + 1);  // tag width, tag 0 reserved
    localparam int DATA_W       = 32;
    localparam int DEST_W       = 5;

    typedef logic [mapValueSize-1:0] tag_t;
    typedef logic [IDX_W-1:0]        idx_t;

    // Tag 0 means "value lives in the architectural regfile".
    localparam tag_t TAG_NONE = '0;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              regwrite;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } rob_entry_t;

    function automatic tag_t idx2tag(input idx_t idx);
        return tag_t'(idx) + tag_t'(1);
    endfunction

    function automatic idx_t tag2idx(input tag_t tag);
        return idx_t'(tag - tag_t'(1));
    endfunction

    // Tags above ROBsize can be encoded in the tag width but name no entry.
    function automatic logic tag_in_range(input tag_t tag);
        return (tag != TAG_NONE) && (int'(tag) <= ROBsize);
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Decode/result-bus/commit signal bundle between the core and the reorder buffer.
// Latency: none, wiring only.
// Backpressure: alloc_ready_o gates decode; result bus and commit are not back-pressured.
interface reorder_buffer_if;
    import rob_pkg::*;

    logic              flush_i;
    logic              alloc_valid_i;
    logic [DEST_W-1:0] alloc_dest_i;
    logic              alloc_regwrite_i;
    logic              alloc_ready_o;
    tag_t              alloc_tag_o;
    logic              complete_valid_i;
    tag_t              complete_tag_i;
    logic [DATA_W-1:0] complete_data_i;
    tag_t              src1_tag_i;
    tag_t              src2_tag_i;
    logic              src1_ready_o;
    logic              src2_ready_o;
    logic [DATA_W-1:0] src1_data_o;
    logic [DATA_W-1:0] src2_data_o;
    logic              commit_valid_o;
    logic [DEST_W-1:0] commit_dest_o;
    logic              commit_regwrite_o;
    logic [DATA_W-1:0] commit_data_o;
    tag_t              commitReadData_i;
    logic [31:0]       resets_o;
    tag_t              count_o;

    // Reorder buffer side.
    modport slave (
        input  flush_i, alloc_valid_i, alloc_dest_i, alloc_regwrite_i,
               complete_valid_i, complete_tag_i, complete_data_i,
               src1_tag_i, src2_tag_i, commitReadData_i,
        output alloc_ready_o, alloc_tag_o, src1_ready_o, src2_ready_o,
               src1_data_o, src2_data_o, commit_valid_o, commit_dest_o,
               commit_regwrite_o, commit_data_o, resets_o, count_o
    );

    // Core side.
    modport master (
        output flush_i, alloc_valid_i, alloc_dest_i, alloc_regwrite_i,
               complete_valid_i, complete_tag_i, complete_data_i,
               src1_tag_i, src2_tag_i, commitReadData_i,
        input  alloc_ready_o, alloc_tag_o, src1_ready_o, src2_ready_o,
               src1_data_o, src2_data_o, commit_valid_o, commit_dest_o,
               commit_regwrite_o, commit_data_o, resets_o, count_o
    );

endinterface

// File: rtl/rob_ptr_counter.sv
// Circular pointer: index plus wrap bit, so head/tail difference gives occupancy.
// Latency: 1 cycle from inc/clr to the new value.
// Backpressure: none; the caller only pulses inc when the move is legal.
module rob_ptr_counter #(
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             wrap
);

    logic [IDX_W:0] ptr_q;

    // Advance by one; index rolls over naturally into the wrap bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (clr) begin
            ptr_q <= '0;
        end else if (inc) begin
            ptr_q <= ptr_q + (IDX_W+1)'(1);
        end
    end

    assign idx  = ptr_q[IDX_W-1:0];
    assign wrap = ptr_q[IDX_W];

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: tags at decode, results from the bus, one commit per cycle.
// Latency: alloc/complete visible next cycle; commit and operand lookup are combinational from state.
// Backpressure: alloc_ready_o drops when all entries are occupied; a commit frees a slot a cycle later.
module reorder_buffer
    import rob_pkg::*;
(
    input logic             clk,
    input logic             reset_n,
    reorder_buffer_if.slave rob
);

    rob_entry_t entries_q [ROBsize];

    idx_t       head_idx;
    idx_t       tail_idx;
    logic       head_wrap;
    logic       tail_wrap;
    rob_entry_t head_ent;
    idx_t       complete_idx;
    logic       alloc_fire;
    logic       commit_fire;
    logic       complete_fire;

    rob_ptr_counter #(.IDX_W(IDX_W)) u_head (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (rob.flush_i),
        .inc     (commit_fire),
        .idx     (head_idx),
        .wrap    (head_wrap)
    );

    rob_ptr_counter #(.IDX_W(IDX_W)) u_tail (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (rob.flush_i),
        .inc     (alloc_fire),
        .idx     (tail_idx),
        .wrap    (tail_wrap)
    );

    // Occupancy falls out of the registered pointers, so it tracks +alloc -commit
    // and a same-cycle commit does not open a slot until the following cycle.
    assign rob.count_o       = tag_t'({tail_wrap, tail_idx} - {head_wrap, head_idx});
    assign rob.alloc_ready_o = (rob.count_o != tag_t'(ROBsize));
    assign rob.alloc_tag_o   = idx2tag(tail_idx);

    // Flush squashes any same-cycle alloc, completion or commit.
    assign alloc_fire    = rob.alloc_valid_i & rob.alloc_ready_o & ~rob.flush_i;
    assign head_ent      = entries_q[head_idx];
    assign commit_fire   = head_ent.valid & head_ent.done & ~rob.flush_i;
    assign complete_idx  = tag2idx(rob.complete_tag_i);
    assign complete_fire = rob.complete_valid_i & tag_in_range(rob.complete_tag_i)
                         & entries_q[complete_idx].valid & ~rob.flush_i;

    assign rob.commit_valid_o    = commit_fire;
    assign rob.commit_dest_o     = head_ent.dest;
    assign rob.commit_regwrite_o = head_ent.regwrite;
    assign rob.commit_data_o     = head_ent.data;

    // Clear the map entry only if it still names the retiring tag; a younger
    // writer of the same register keeps its mapping.
    always_comb begin
        rob.resets_o = '0;
        if (commit_fire && head_ent.regwrite && (rob.commitReadData_i == idx2tag(head_idx))) begin
            rob.resets_o = 32'h1 << head_ent.dest;
        end
    end

    // Operand lookup: {ready, data}. A result on the bus this cycle wins over the stored copy.
    function automatic logic [DATA_W:0] operand(input tag_t tag, input logic cv, input tag_t ct,
                                                input logic [DATA_W-1:0] cd);
        rob_entry_t e;
        e = entries_q[tag2idx(tag)];
        if (!tag_in_range(tag)) begin
            return '0;
        end
        if (cv && (ct == tag)) begin
            return {1'b1, cd};
        end
        return {e.valid & e.done, e.data};
    endfunction

    assign {rob.src1_ready_o, rob.src1_data_o} =
        operand(rob.src1_tag_i, rob.complete_valid_i, rob.complete_tag_i, rob.complete_data_i);
    assign {rob.src2_ready_o, rob.src2_data_o} =
        operand(rob.src2_tag_i, rob.complete_valid_i, rob.complete_tag_i, rob.complete_data_i);

    // Entry array: complete sets done/data, commit clears the head, alloc fills the tail.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROBsize; i++) begin
                entries_q[i] <= '0;
            end
        end else if (rob.flush_i) begin
            for (int i = 0; i < ROBsize; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            if (complete_fire) begin
                entries_q[complete_idx].done <= 1'b1;
                entries_q[complete_idx].data <= rob.complete_data_i;
            end
            if (commit_fire) begin
                entries_q[head_idx] <= '0;
            end
            if (alloc_fire) begin
                entries_q[tail_idx] <= '{valid:    1'b1,
                                         done:     1'b0,
                                         regwrite: rob.alloc_regwrite_i,
                                         dest:     rob.alloc_dest_i,
                                         data:     '0};
            end
        end
    end

endmodule
